// File: rtl/bist_checker.sv
// bist_checker: delays BIST read expectations to SRAM read latency and checks read data.
// Latency: compare READ_LATENCY cycles after launch; check_done <= READ_LATENCY+1 cycles after last read.
// Backpressure: none; the pipe advances every cycle regardless of en, so reads are never stalled.
//
// Ports:
//   clk, rst        - BIST clock, synchronous active-high reset
//   en, re          - enable and read strobe from the pattern generator (launch on en && re)
//   addr, expected  - read address and expected word from the pattern generator
//   patgen_done     - pattern generator has finished issuing reads
//   dout            - SRAM read data
//   check_done      - sticky: generator done and every in-flight read retired
//   fail            - sticky: at least one mismatch
//   fail_addr/fail_expected/fail_actual - capture of the first mismatch
//   err_count       - saturating mismatch count
//   fail_bits       - accumulated per-bit failure map
// Optional: define BIST_CHECKER_BITMAP_EN to build the fail_bits accumulator; otherwise fail_bits is 0.
module bist_checker #(
  parameter int ADDR_WIDTH    = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int READ_LATENCY  = 1,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     re,
  input  logic [ADDR_WIDTH-1:0]    addr,
  input  logic [DATA_WIDTH-1:0]    expected,
  input  logic                     patgen_done,
  input  logic [DATA_WIDTH-1:0]    dout,
  output logic                     check_done,
  output logic                     fail,
  output logic [ADDR_WIDTH-1:0]    fail_addr,
  output logic [DATA_WIDTH-1:0]    fail_expected,
  output logic [DATA_WIDTH-1:0]    fail_actual,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  output logic [DATA_WIDTH-1:0]    fail_bits
);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t state_q, state_d;

  // Shift pipe: stage 0 is loaded on the launch edge, the last stage lines up with dout.
  logic [READ_LATENCY-1:0] pipe_vld;
  logic [ADDR_WIDTH-1:0]   pipe_addr [READ_LATENCY];
  logic [DATA_WIDTH-1:0]   pipe_exp  [READ_LATENCY];

  logic                    cmp_vld;
  logic [ADDR_WIDTH-1:0]   cmp_addr;
  logic [DATA_WIDTH-1:0]   cmp_exp;
  logic                    mismatch;
  logic                    pipe_busy;

  // Only the valid bits need reset; stale addr/expected in a bubble are never compared.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= en & re;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    pipe_addr[0] <= addr;
    pipe_exp[0]  <= expected;
    for (int i = 1; i < READ_LATENCY; i++) begin
      pipe_addr[i] <= pipe_addr[i-1];
      pipe_exp[i]  <= pipe_exp[i-1];
    end
  end

  assign cmp_vld   = pipe_vld[READ_LATENCY-1];
  assign cmp_addr  = pipe_addr[READ_LATENCY-1];
  assign cmp_exp   = pipe_exp[READ_LATENCY-1];
  assign mismatch  = cmp_vld && (dout != cmp_exp);
  // Includes the last stage, so a read being compared this edge still holds off DONE.
  assign pipe_busy = |pipe_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (patgen_done) state_d = DRAIN;
      DRAIN:   if (!pipe_busy)  state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = RUN;
    endcase
  end

  assign check_done = (state_q == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      fail          <= 1'b0;
      fail_addr     <= '0;
      fail_expected <= '0;
      fail_actual   <= '0;
      err_count     <= '0;
    end else if (mismatch) begin
      fail <= 1'b1;
      // First failure only: capture is frozen once fail is set.
      if (!fail) begin
        fail_addr     <= cmp_addr;
        fail_expected <= cmp_exp;
        fail_actual   <= dout;
      end
      if (err_count != {ERR_CNT_WIDTH{1'b1}}) begin
        err_count <= err_count + ERR_CNT_WIDTH'(1);
      end
    end
  end

`ifdef BIST_CHECKER_BITMAP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fail_bits <= '0;
    end else if (cmp_vld) begin
      fail_bits <= fail_bits | (dout ^ cmp_exp);
    end
  end
`else
  assign fail_bits = '0;
`endif

endmodule

// File: tb/tb_bist_checker.sv
// tb_bist_checker: two checker instances (latency 1 / 16-bit count, latency 3 / 2-bit count)
// share one pattern-generator stream; each sees its own latency-shifted SRAM model.
// A scoreboard queue of launched reads drives a reference model compared every cycle.
module tb_bist_checker;
  localparam int AW   = 2;
  localparam int DW   = 8;
  localparam int RL0  = 1;
  localparam int RL1  = 3;
  localparam int ECW0 = 16;
  localparam int ECW1 = 2;
`ifdef BIST_CHECKER_BITMAP_EN
  localparam bit BM = 1'b1;
`else
  localparam bit BM = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, re, patgen_done;
  logic [AW-1:0] addr;
  logic [DW-1:0] expected, dout0, dout1;
  logic cd0, f0, cd1, f1;
  logic [AW-1:0] fa0, fa1;
  logic [DW-1:0] fe0, fx0, fb0, fe1, fx1, fb1;
  logic [ECW0-1:0] ec0;
  logic [ECW1-1:0] ec1;

  bist_checker #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL0), .ERR_CNT_WIDTH(ECW0)) u0 (
    .clk(clk), .rst(rst), .en(en), .re(re), .addr(addr), .expected(expected),
    .patgen_done(patgen_done), .dout(dout0), .check_done(cd0), .fail(f0), .fail_addr(fa0),
    .fail_expected(fe0), .fail_actual(fx0), .err_count(ec0), .fail_bits(fb0));

  bist_checker #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL1), .ERR_CNT_WIDTH(ECW1)) u1 (
    .clk(clk), .rst(rst), .en(en), .re(re), .addr(addr), .expected(expected),
    .patgen_done(patgen_done), .dout(dout1), .check_done(cd1), .fail(f1), .fail_addr(fa1),
    .fail_expected(fe1), .fail_actual(fx1), .err_count(ec1), .fail_bits(fb1));

  typedef struct {
    int            inst;
    int            launch;
    int            due;
    logic [AW-1:0] a;
    logic [DW-1:0] e;
    logic [DW-1:0] d;
  } item_t;

  typedef struct {
    int            inst;
    int            due;
    logic [DW-1:0] d;
  } resp_t;

  item_t sbq[$];
  resp_t rq[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] mem [4];
  logic [DW-1:0] sa0 [4];

  // Reference state per instance
  bit            r_drain [2];
  bit            r_done  [2];
  bit            r_fail  [2];
  int            r_err   [2];
  int            r_max   [2];
  logic [AW-1:0] r_fa    [2];
  logic [DW-1:0] r_fe    [2];
  logic [DW-1:0] r_fx    [2];
  logic [DW-1:0] r_fb    [2];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp_v, cyc);
    end
  endtask

  function automatic logic [DW-1:0] sram(input logic [AW-1:0] a);
    return mem[a] & ~sa0[a];
  endfunction

  // ---------------- SRAM response model / driver ----------------
  task automatic drive_dout();
    resp_t keep[$];
    dout0 = DW'($urandom);
    dout1 = DW'($urandom);
    foreach (rq[i]) begin
      if (rq[i].due == cyc + 1) begin
        if (rq[i].inst == 0) dout0 = rq[i].d;
        else                 dout1 = rq[i].d;
      end else if (rq[i].due > cyc + 1) begin
        keep.push_back(rq[i]);
      end
    end
    rq = keep;
  endtask

  task automatic tick(input logic en_v, input logic re_v, input logic [AW-1:0] a,
                      input logic [DW-1:0] e, input logic pd);
    logic [DW-1:0] d;
    en = en_v; re = re_v; addr = a; expected = e; patgen_done = pd;
    @(posedge clk);
    #1;
    if (!rst && en_v && re_v) begin
      d = sram(a);
      sbq.push_back('{inst: 0, launch: cyc, due: cyc + RL0, a: a, e: e, d: d});
      sbq.push_back('{inst: 1, launch: cyc, due: cyc + RL1, a: a, e: e, d: d});
      rq.push_back('{inst: 0, due: cyc + RL0, d: d});
      rq.push_back('{inst: 1, due: cyc + RL1, d: d});
    end
    drive_dout();
  endtask

  task automatic idle(input int n, input logic pd);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, '0, '0, pd);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1'b0, 1'b0, '0, '0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) sa0[i] = '0;
  endtask

  task automatic march(input logic [DW-1:0] v, input logic pd);
    for (int i = 0; i < 4; i++) mem[i] = v;
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, AW'(i), v, pd);
  endtask

  task automatic chk_status(input string tag, input logic ef, input logic [AW-1:0] efa,
                            input logic [DW-1:0] efe, input logic [DW-1:0] efx,
                            input int eerr0, input int eerr1, input logic [DW-1:0] efb);
    chk({tag, ".u0.fail"}, f0, ef);
    chk({tag, ".u1.fail"}, f1, ef);
    chk({tag, ".u0.fail_addr"}, fa0, efa);
    chk({tag, ".u1.fail_addr"}, fa1, efa);
    chk({tag, ".u0.fail_expected"}, fe0, efe);
    chk({tag, ".u1.fail_expected"}, fe1, efe);
    chk({tag, ".u0.fail_actual"}, fx0, efx);
    chk({tag, ".u1.fail_actual"}, fx1, efx);
    chk({tag, ".u0.err_count"}, ec0, eerr0);
    chk({tag, ".u1.err_count"}, ec1, eerr1);
    chk({tag, ".u0.fail_bits"}, fb0, BM ? efb : '0);
    chk({tag, ".u1.fail_bits"}, fb1, BM ? efb : '0);
  endtask

  // ---------------- Monitor / reference model ----------------
  logic m_rst, m_pd;

  task automatic cmp_inst(input int k, input logic cd, input logic f, input logic [AW-1:0] fa,
                          input logic [DW-1:0] fe, input logic [DW-1:0] fx,
                          input logic [15:0] ec, input logic [DW-1:0] fb);
    chk($sformatf("mon.u%0d.check_done", k), cd, r_done[k]);
    chk($sformatf("mon.u%0d.fail", k), f, r_fail[k]);
    chk($sformatf("mon.u%0d.err_count", k), ec, r_err[k]);
    chk($sformatf("mon.u%0d.fail_addr", k), fa, r_fa[k]);
    chk($sformatf("mon.u%0d.fail_expected", k), fe, r_fe[k]);
    chk($sformatf("mon.u%0d.fail_actual", k), fx, r_fx[k]);
    chk($sformatf("mon.u%0d.fail_bits", k), fb, BM ? r_fb[k] : '0);
  endtask

  task automatic model_step();
    bit    busy [2];
    item_t keep [$];
    int    k;
    if (m_rst) begin
      for (int j = 0; j < 2; j++) begin
        r_drain[j] = 0; r_done[j] = 0; r_fail[j] = 0; r_err[j] = 0;
        r_fa[j] = '0; r_fe[j] = '0; r_fx[j] = '0; r_fb[j] = '0;
      end
      sbq.delete();
    end else begin
      busy[0] = 0;
      busy[1] = 0;
      // Reads launched before this edge and not yet retired are still in flight.
      foreach (sbq[i]) if (sbq[i].launch < cyc) busy[sbq[i].inst] = 1;
      for (int j = 0; j < 2; j++) begin
        if (r_drain[j] && !busy[j]) r_done[j] = 1;
        if (m_pd) r_drain[j] = 1;
      end
      foreach (sbq[i]) begin
        if (sbq[i].due == cyc) begin
          k = sbq[i].inst;
          if (sbq[i].e != sbq[i].d) begin
            if (!r_fail[k]) begin
              r_fa[k] = sbq[i].a;
              r_fe[k] = sbq[i].e;
              r_fx[k] = sbq[i].d;
            end
            r_fail[k] = 1;
            if (r_err[k] < r_max[k]) r_err[k]++;
          end
          r_fb[k] = r_fb[k] | (sbq[i].e ^ sbq[i].d);
        end else begin
          keep.push_back(sbq[i]);
        end
      end
      sbq = keep;
    end
    cmp_inst(0, cd0, f0, fa0, fe0, fx0, 16'(ec0), fb0);
    cmp_inst(1, cd1, f1, fa1, fe1, fx1, 16'(ec1), fb1);
  endtask

  always @(posedge clk) begin
    m_rst = rst;
    m_pd  = patgen_done;
    #2;
    model_step();
  end

  // ---------------- Stimulus ----------------
  initial begin
    int t0, t1, pd_at;
    logic pd;
    logic [AW-1:0] a;
    logic [DW-1:0] e;
    r_max[0] = (1 << ECW0) - 1;
    r_max[1] = (1 << ECW1) - 1;
    rst = 1'b1; en = 1'b0; re = 1'b0; addr = '0; expected = '0; patgen_done = 1'b0;
    dout0 = '0; dout1 = '0;
    for (int i = 0; i < 4; i++) begin mem[i] = '0; sa0[i] = '0; end

    // Reset state
    tick(1'b0, 1'b0, '0, '0, 1'b0);
    tick(1'b0, 1'b0, '0, '0, 1'b0);
    rst = 1'b0;
    chk("reset.u0.check_done", cd0, 1'b0);
    chk("reset.u1.check_done", cd1, 1'b0);
    chk_status("reset", 1'b0, '0, '0, '0, 0, 0, '0);

    // Clean zero/one march, then done latency
    march(8'h00, 1'b0);
    march(8'hFF, 1'b0);
    tick(1'b0, 1'b0, '0, '0, 1'b1);
    t0 = -1; t1 = -1;
    for (int t = 1; t <= 10; t++) begin
      tick(1'b0, 1'b0, '0, '0, 1'b1);
      if (cd0 && t0 < 0) t0 = t;
      if (cd1 && t1 < 0) t1 = t;
    end
    chk("clean.u0.done_latency", t0, 1);
    chk("clean.u1.done_latency", t1, 3);
    chk_status("clean", 1'b0, '0, '0, '0, 0, 0, '0);
    // Stray mismatching read after DONE still counts
    tick(1'b1, 1'b1, 2'd0, 8'hAA, 1'b1);
    idle(4, 1'b1);
    chk("stray.u0.check_done", cd0, 1'b1);
    chk("stray.u1.check_done", cd1, 1'b1);
    chk_status("stray", 1'b1, 2'd0, 8'hAA, 8'hFF, 1, 1, 8'h55);

    // Single stuck-at-0 on bit 3 of addr 2
    do_reset();
    sa0[2] = 8'h08;
    march(8'h00, 1'b0);
    march(8'hFF, 1'b0);
    idle(5, 1'b0);
    chk_status("single", 1'b1, 2'd2, 8'hFF, 8'hF7, 1, 1, 8'h08);

    // Two faulty addresses: capture stays on the first
    do_reset();
    sa0[1] = 8'h10;
    sa0[3] = 8'h01;
    march(8'hFF, 1'b0);
    idle(5, 1'b0);
    chk_status("multi", 1'b1, 2'd1, 8'hFF, 8'hEF, 2, 2, 8'h11);

    // Saturation of the 2-bit counter
    do_reset();
    for (int i = 0; i < 4; i++) mem[i] = 8'h00;
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 2'd0, 8'h5A, 1'b0);
    idle(5, 1'b0);
    chk_status("sat", 1'b1, 2'd0, 8'h5A, 8'h00, 5, 3, 8'h5A);

    // en low for 3 cycles right after a launch
    do_reset();
    tick(1'b1, 1'b1, 2'd1, 8'h33, 1'b0);
    tick(1'b0, 1'b1, 2'd2, 8'hC3, 1'b0);
    chk("engap1.u0.err", ec0, 1);
    chk("engap1.u1.err", ec1, 0);
    tick(1'b0, 1'b1, 2'd3, 8'h3C, 1'b0);
    chk("engap2.u1.err", ec1, 0);
    tick(1'b0, 1'b1, 2'd0, 8'h99, 1'b0);
    chk("engap3.u1.err", ec1, 1);
    chk("engap3.u1.fail_addr", fa1, 2'd1);
    idle(5, 1'b0);
    chk("engap_end.u0.err", ec0, 1);
    chk("engap_end.u1.err", ec1, 1);

    // Reset with reads in flight and mismatching dout
    do_reset();
    tick(1'b1, 1'b1, 2'd0, 8'hFF, 1'b0);
    tick(1'b1, 1'b1, 2'd1, 8'hFF, 1'b0);
    rst = 1'b1;
    tick(1'b1, 1'b1, 2'd2, 8'hFF, 1'b1);
    rst = 1'b0;
    idle(5, 1'b0);
    chk("midrst.u0.check_done", cd0, 1'b0);
    chk("midrst.u1.check_done", cd1, 1'b0);
    chk_status("midrst", 1'b0, '0, '0, '0, 0, 0, '0);

    // Randomized runs
    for (int r = 0; r < 6; r++) begin
      do_reset();
      for (int i = 0; i < 4; i++) begin
        mem[i] = DW'($urandom);
        sa0[i] = ($urandom_range(0, 2) == 0) ? DW'(1 << $urandom_range(0, DW - 1)) : '0;
      end
      pd_at = $urandom_range(30, 60);
      pd = 1'b0;
      for (int c = 0; c < 70; c++) begin
        if (c == pd_at) pd = 1'b1;
        a = AW'($urandom);
        e = ($urandom_range(0, 7) == 0) ? DW'($urandom) : mem[a];
        tick($urandom_range(0, 3) != 0, $urandom_range(0, 4) < 3, a, e, pd);
      end
      t0 = 0;
      while (!(cd0 && cd1) && t0 < 20) begin
        tick(1'b0, 1'b0, '0, '0, 1'b1);
        t0++;
      end
      chk($sformatf("rand%0d.done_reached", r), cd0 && cd1, 1'b1);
    end

    idle(2, 1'b0);
    #5;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bist_checker.md
Name: bist_checker

Overview:
- Downstream stage of the BIST pattern generator in the SRAM BIST datapath.
- Takes the generator's read strobes, addresses and expected data, and delays them to match SRAM read latency.
- Compares each delayed expected word against SRAM read data and keeps sticky pass/fail status, first-failure capture and a saturating error count.
- Signals checking complete once the generator reports done and all in-flight reads have retired.

Parameters:
- ADDR_WIDTH, 5, SRAM address width.
- DATA_WIDTH, 32, SRAM data width.
- READ_LATENCY, 1, cycles from the re/addr launch edge to valid dout; legal range 1..8.
- ERR_CNT_WIDTH, 16, width of the error counter.

Ports:
- clk  input  1  BIST clock; same clock as the pattern generator and SRAM.
- rst  input  1  synchronous, active-high reset.
- en  input  1  BIST enable; the same en that drives the pattern generator.
- re  input  1  read strobe from the pattern generator.
- addr  input  ADDR_WIDTH  read address from the pattern generator.
- expected  input  DATA_WIDTH  expected read data from the pattern generator.
- patgen_done  input  1  done flag from the pattern generator.
- dout  input  DATA_WIDTH  SRAM read data.
- check_done  output  1  sticky; checking complete.
- fail  output  1  sticky; at least one mismatch seen.
- fail_addr  output  ADDR_WIDTH  address of the first mismatch.
- fail_expected  output  DATA_WIDTH  expected word at the first mismatch.
- fail_actual  output  DATA_WIDTH  dout at the first mismatch.
- err_count  output  ERR_CNT_WIDTH  number of mismatching reads, saturating.
- fail_bits  output  DATA_WIDTH  per-bit failure map (see Optional Feature).

Behaviour:
- Reset:
  - All outputs are 0 on the cycle after rst is sampled high.
  - Pipeline valid bits are cleared and the FSM goes to RUN.
  - rst asserted mid-test discards all in-flight reads; no compare occurs for them.
- Launch:
  - A read launches on a clk edge where en && re is high.
  - On launch, {valid=1, addr, expected} enters stage 0 of a READ_LATENCY-deep shift pipe.
  - If en && re is low on that edge, a bubble (valid=0) enters instead.
- Pipe advance:
  - The pipe shifts every cycle, independent of en, because SRAM latency is fixed in cycles.
  - Deasserting en therefore never stalls or drops reads already in flight.
- Compare:
  - A compare happens on the edge where the pipe's last stage holds valid=1.
  - That edge is exactly READ_LATENCY cycles after the launch edge; dout is sampled on the same edge.
  - Mismatch condition: dout != expected, full-width compare with no masking.
- On each mismatch:
  - fail <= 1 (sticky).
  - err_count <= err_count + 1, holding at all-ones with no wrap.
  - If fail was 0 before this edge, capture fail_addr, fail_expected and fail_actual.
  - Capture registers never change again until rst.
- FSM states: RUN, DRAIN, DONE.
  - RUN -> DRAIN on an edge where patgen_done is high.
  - DRAIN -> DONE on the first edge where no pipe stage holds valid=1, including a read compared on that same edge.
  - DONE is terminal until rst.
  - check_done = (state == DONE), registered.
- Reads launched while patgen_done is high are still tracked and compared; DRAIN waits for them.
- Total latency from the last launched read to check_done high is at most READ_LATENCY + 1 cycles.
- Compares continue in DONE if stray reads arrive. fail and err_count still update; check_done stays 1.

Optional Feature:
- Macro: BIST_CHECKER_BITMAP_EN.
- Defined:
  - On every compare, fail_bits <= fail_bits | (dout ^ expected).
  - The map accumulates across the whole test and is cleared only by rst.
- Not defined:
  - fail_bits is tied to 0 and no accumulation register is built.
  - All other behaviour is unchanged.

Test Plan:
- Clean pass, READ_LATENCY=1, ADDR_WIDTH=2, DATA_WIDTH=8, SRAM model correct over a zero/one march -> check_done=1 within 2 cycles of patgen_done; fail=0; err_count=0.
- Single fault, READ_LATENCY=2, SRAM bit 3 of addr 2 stuck-at-0, all-ones read phase -> fail=1; fail_addr=2; fail_expected=8'hFF; fail_actual=8'hF7; err_count=1; fail_bits=8'h08 with the macro defined, 0 without.
- Multiple faults: addr 1 and addr 3 both mismatch -> capture holds addr 1 data; err_count=2.
- Saturation, ERR_CNT_WIDTH=2, 5 mismatching reads -> err_count=3, no wrap.
- en deasserted for 3 cycles right after a launch, READ_LATENCY=3 -> the read is still compared 3 cycles after launch; no spurious compares during the en-low gap.
- rst pulsed while 2 reads are in flight, with dout mismatching on those cycles -> fail=0, err_count=0 afterward; FSM in RUN; check_done=0.
